bpu_dyn_2023211063: RTL

//  Parametrised dynamic branch predictor; drop-in successor to the static BTFN predictor in IF/ID.

---
 rtl/bpu_dyn_2023211063.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bpu_dyn_2023211063.sv
// Dynamic branch predictor: bimodal 2-bit BHT, optional return-address stack (macro BPU_RAS_EN).
// Latency: prediction is combinational (0 cycles); BHT and RAS updates commit at the next clk edge.
// Backpressure: none; state changes only on inst_valid_i / upd_valid_i, so stalled slots are inert.
module bpu_dyn_2023211063 #(
    parameter int ADDR_W    = 32,
    parameter int BHT_IDX_W = 6,
    parameter int PRDT_MODE = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inst_valid_i,
    input  logic              inst_jal_i,
    input  logic              inst_jalr_i,
    input  logic              inst_bxx_i,
    input  logic              rd_link_i,
    input  logic              rs1_link_i,
    input  logic [ADDR_W-1:0] jump_and_branch_imm_i,
    output logic              prdt_taken_o,
    output logic [ADDR_W-1:0] prdt_addr_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i
);

    localparam int BHT_N  = 1 << BHT_IDX_W;
    localparam bit BHT_ON = (PRDT_MODE != 0);

    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX_W-1:0] prd_idx;
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [ADDR_W-1:0]    jb_target;
    logic                 bxx_taken;
    logic                 jalr_taken;
    logic [ADDR_W-1:0]    jalr_target;

    assign prd_idx   = pc_i[BHT_IDX_W+1:2];
    assign upd_idx   = upd_pc_i[BHT_IDX_W+1:2];
    assign jb_target = pc_i + jump_and_branch_imm_i;
    assign bxx_taken = BHT_ON ? bht[prd_idx][1] : jump_and_branch_imm_i[ADDR_W-1];

    // Writes land at the edge, so a same-cycle read of the same index still sees the old counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (BHT_ON && upd_valid_i) begin
            if (upd_taken_i) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'd1;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'd1;
            end
        end
    end

`ifdef BPU_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr;
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  nxt_ptr;
    logic [CNT_W-1:0]  ras_cnt;
    logic [ADDR_W-1:0] link_addr;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_repl;

    // ras_ptr is the next free slot; the ring lets a push on a full stack drop the oldest entry.
    assign top_ptr   = (ras_ptr == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr - PTR_W'(1);
    assign nxt_ptr   = (ras_ptr == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + PTR_W'(1);
    assign link_addr = pc_i + ADDR_W'(4);

    always_comb begin
        ras_push    = 1'b0;
        ras_pop     = 1'b0;
        ras_repl    = 1'b0;
        jalr_taken  = 1'b0;
        jalr_target = jb_target;
        if (inst_jal_i) begin
            ras_push = rd_link_i;
        end else if (inst_jalr_i) begin
            if (rs1_link_i && ras_cnt != '0) begin
                jalr_taken  = 1'b1;
                jalr_target = ras[top_ptr];
                ras_repl    = rd_link_i;
                ras_pop     = !rd_link_i;
            end else begin
                ras_push = rd_link_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (inst_valid_i) begin
            if (ras_push) begin
                ras[ras_ptr] <= link_addr;
                ras_ptr      <= nxt_ptr;
                if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (ras_pop) begin
                ras_ptr <= top_ptr;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end else if (ras_repl) begin
                ras[top_ptr] <= link_addr;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{upd_pc_i[ADDR_W-1:BHT_IDX_W+2], upd_pc_i[1:0]};
`else
    assign jalr_taken  = 1'b0;
    assign jalr_target = jb_target;

    logic unused_bits;
    assign unused_bits = ^{upd_pc_i[ADDR_W-1:BHT_IDX_W+2], upd_pc_i[1:0],
                           rd_link_i, rs1_link_i, inst_valid_i};
`endif

    always_comb begin
        prdt_taken_o = 1'b0;
        prdt_addr_o  = jb_target;
        if (inst_jal_i) begin
            prdt_taken_o = 1'b1;
        end else if (inst_jalr_i) begin
            prdt_taken_o = jalr_taken;
            prdt_addr_o  = jalr_target;
        end else if (inst_bxx_i) begin
            prdt_taken_o = bxx_taken;
        end
    end

endmodule
